// File: rtl/player_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : player_round_ctrl
// Description : Card-round sequencer for NUM_PLAYERS hands against a dealer,
//               with result lights and saturating round / win tallies.
// Revision    : 1.0 - initial release
// ============================================================================
module player_round_ctrl #(
    parameter int NUM_PLAYERS  = 2,
    parameter int TALLY_W      = 8,
    parameter int AUTO_ADVANCE = 1
) (
    input  logic                           slow_clock,
    input  logic                           resetb,
    input  logic                           advance,
    input  logic [4*NUM_PLAYERS-1:0]       pscore,
    input  logic [4*NUM_PLAYERS-1:0]       pcard3,
    input  logic [3:0]                     dscore,
    output logic [3*NUM_PLAYERS-1:0]       load_pcard,
    output logic [2:0]                     load_dcard,
    output logic [NUM_PLAYERS-1:0]         player_win_light,
    output logic [NUM_PLAYERS-1:0]         dealer_win_light,
    output logic                           endround,
    output logic [TALLY_W-1:0]             round_count,
    output logic [TALLY_W*NUM_PLAYERS-1:0] player_tally
);

    // One spare bit keeps "idx beyond last player" representable for every N.
    localparam int IDX_W = $clog2(NUM_PLAYERS) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PLAYERS - 1);

    typedef enum logic [2:0] {
        S_RST = 3'd0,
        S_P1  = 3'd1,
        S_DC1 = 3'd2,
        S_P2  = 3'd3,
        S_DC2 = 3'd4,
        S_P3  = 3'd5,
        S_DC3 = 3'd6,
        S_END = 3'd7
    } state_t;

    state_t                   state, state_next;
    logic [IDX_W-1:0]         idx, idx_next;
    logic [NUM_PLAYERS-1:0]   draw_mask, draw_mask_next, draw_now;
    logic                     nat0, nat0_next;
    logic [3:0]               ps [NUM_PLAYERS];
    logic [TALLY_W-1:0]       tally [NUM_PLAYERS];

    generate
        for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
            assign ps[g]       = pscore[4*g +: 4];
            assign draw_now[g] = (pscore[4*g +: 4] <= 4'd5);
            assign player_tally[TALLY_W*g +: TALLY_W] = tally[g];
        end
        if (NUM_PLAYERS > 1) begin : g_unused
            // Only player 0's third card feeds the dealer table.
            logic unused_pcard3;
            assign unused_pcard3 = ^pcard3[4*NUM_PLAYERS-1:4];
        end
    endgenerate

    // Dealer third-card rule, keyed on player 0's third card when it drew.
    function automatic logic dealer_draws(input logic       mask0,
                                          input logic       n0,
                                          input logic [3:0] ds,
                                          input logic [3:0] pc3);
        logic r;
        r = 1'b0;
        if (mask0) begin
            case (ds)
                4'd0, 4'd1, 4'd2: r = 1'b1;
                4'd3:             r = (pc3 != 4'd8);
                4'd4:             r = (pc3 >= 4'd2) && (pc3 <= 4'd7);
                4'd5:             r = (pc3 >= 4'd4) && (pc3 <= 4'd7);
                4'd6:             r = (pc3 >= 4'd6) && (pc3 <= 4'd7);
                default:          r = 1'b0;
            endcase
        end else begin
            r = (ds <= 4'd5) && !n0;
        end
        return r;
    endfunction

    always_comb begin
        state_next     = state;
        idx_next       = idx;
        draw_mask_next = draw_mask;
        nat0_next      = nat0;
        case (state)
            S_RST: begin
                state_next = S_P1;
                idx_next   = '0;
            end
            S_P1: begin
                if (idx == LAST_IDX) begin
                    state_next = S_DC1;
                    idx_next   = '0;
                end else begin
                    idx_next = idx + IDX_W'(1);
                end
            end
            S_DC1: begin
                state_next = S_P2;
                idx_next   = '0;
            end
            S_P2: begin
                if (idx == LAST_IDX) begin
                    state_next = S_DC2;
                    idx_next   = '0;
                end else begin
                    idx_next = idx + IDX_W'(1);
                end
            end
            S_DC2: begin
                draw_mask_next = draw_now;
                nat0_next      = (ps[0] >= 4'd8);
                idx_next       = '0;
                if (dscore >= 4'd8)
                    state_next = S_END;
                else if (|draw_now)
                    state_next = S_P3;
                else if (dealer_draws(draw_now[0], (ps[0] >= 4'd8), dscore, pcard3[3:0]))
                    state_next = S_DC3;
                else
                    state_next = S_END;
            end
            S_P3: begin
                if (idx == LAST_IDX) begin
                    idx_next   = '0;
                    state_next = dealer_draws(draw_mask[0], nat0, dscore, pcard3[3:0])
                                 ? S_DC3 : S_END;
                end else begin
                    idx_next = idx + IDX_W'(1);
                end
            end
            S_DC3: state_next = S_END;
            S_END: begin
                if ((AUTO_ADVANCE != 0) || advance) begin
                    state_next = S_RST;
                    idx_next   = '0;
                end
            end
            default: begin
                state_next = S_RST;
                idx_next   = '0;
            end
        endcase
        if (idx > LAST_IDX) begin
            state_next = S_RST;
            idx_next   = '0;
        end
    end

    always_ff @(negedge slow_clock or posedge resetb) begin
        if (resetb) begin
            state       <= S_RST;
            idx         <= '0;
            draw_mask   <= '0;
            nat0        <= 1'b0;
            round_count <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++) tally[i] <= '0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            draw_mask <= draw_mask_next;
            nat0      <= nat0_next;
            // Tallies move only on the entry edge, so a held END counts once.
            if ((state_next == S_END) && (state != S_END)) begin
                if (round_count != '1) round_count <= round_count + TALLY_W'(1);
                for (int i = 0; i < NUM_PLAYERS; i++) begin
                    if ((ps[i] > dscore) && (tally[i] != '1))
                        tally[i] <= tally[i] + TALLY_W'(1);
                end
            end
        end
    end

    always_comb begin
        load_pcard       = '0;
        load_dcard       = '0;
        player_win_light = '0;
        dealer_win_light = '0;
        endround         = 1'b0;
        case (state)
            S_DC1: load_dcard[0] = 1'b1;
            S_DC2: load_dcard[1] = 1'b1;
            S_DC3: load_dcard[2] = 1'b1;
            S_END: endround      = 1'b1;
            default: ;
        endcase
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (idx == IDX_W'(i)) begin
                if (state == S_P1) load_pcard[3*i]     = 1'b1;
                if (state == S_P2) load_pcard[3*i + 1] = 1'b1;
                if (state == S_P3) load_pcard[3*i + 2] = draw_mask[i];
            end
            if (state == S_END) begin
                player_win_light[i] = (ps[i] >= dscore);
                dealer_win_light[i] = (dscore >= ps[i]);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_player_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_player_round_ctrl
// Description : Scoreboard bench for player_round_ctrl in three configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_player_round_ctrl;

    logic slow_clock;
    logic rst_a, rst_b, rst_c, adv_c;
    logic [7:0] ps_a, pc3_a, ps_c, pc3_c;
    logic [3:0] ps_b, pc3_b, ds_a, ds_b, ds_c;

    logic [5:0] lp_a, lp_c;
    logic [2:0] lp_b, ld_a, ld_b, ld_c;
    logic [1:0] pw_a, dw_a, pw_c, dw_c;
    logic       pw_b, dw_b, er_a, er_b, er_c;
    logic [7:0] rc_a, rc_b, pt_b;
    logic [15:0] pt_a;
    logic [1:0] rc_c;
    logic [3:0] pt_c;

    player_round_ctrl #(.NUM_PLAYERS(2), .TALLY_W(8), .AUTO_ADVANCE(1)) dut_a (
        .slow_clock(slow_clock), .resetb(rst_a), .advance(1'b0),
        .pscore(ps_a), .pcard3(pc3_a), .dscore(ds_a),
        .load_pcard(lp_a), .load_dcard(ld_a),
        .player_win_light(pw_a), .dealer_win_light(dw_a),
        .endround(er_a), .round_count(rc_a), .player_tally(pt_a));

    player_round_ctrl #(.NUM_PLAYERS(1), .TALLY_W(8), .AUTO_ADVANCE(1)) dut_b (
        .slow_clock(slow_clock), .resetb(rst_b), .advance(1'b0),
        .pscore(ps_b), .pcard3(pc3_b), .dscore(ds_b),
        .load_pcard(lp_b), .load_dcard(ld_b),
        .player_win_light(pw_b), .dealer_win_light(dw_b),
        .endround(er_b), .round_count(rc_b), .player_tally(pt_b));

    player_round_ctrl #(.NUM_PLAYERS(2), .TALLY_W(2), .AUTO_ADVANCE(0)) dut_c (
        .slow_clock(slow_clock), .resetb(rst_c), .advance(adv_c),
        .pscore(ps_c), .pcard3(pc3_c), .dscore(ds_c),
        .load_pcard(lp_c), .load_dcard(ld_c),
        .player_win_light(pw_c), .dealer_win_light(dw_c),
        .endround(er_c), .round_count(rc_c), .player_tally(pt_c));

    initial begin
        slow_clock = 1'b1;
        forever #5 slow_clock = ~slow_clock;
    end

    typedef struct packed {
        logic [5:0] lp;
        logic [2:0] ld;
        logic       er;
        logic [1:0] pw;
        logic [1:0] dw;
    } obs_t;

    obs_t sbq[$];
    int checks = 0;
    int errors = 0;

    function automatic void push(input logic [5:0] lp, input logic [2:0] ld,
                                 input logic er, input logic [1:0] pw, input logic [1:0] dw);
        obs_t e;
        e.lp = lp; e.ld = ld; e.er = er; e.pw = pw; e.dw = dw;
        sbq.push_back(e);
    endfunction

    // P1 per player, DC1, P2 per player, DC2
    function automatic void push_base(input int n);
        for (int i = 0; i < n; i++) push(6'd1 << (3*i), 3'b000, 1'b0, 2'b00, 2'b00);
        push(6'd0, 3'b001, 1'b0, 2'b00, 2'b00);
        for (int i = 0; i < n; i++) push(6'd2 << (3*i), 3'b000, 1'b0, 2'b00, 2'b00);
        push(6'd0, 3'b010, 1'b0, 2'b00, 2'b00);
    endfunction

    function automatic obs_t observe(input int sel);
        obs_t o;
        case (sel)
            0:       o = '{lp: lp_a, ld: ld_a, er: er_a, pw: pw_a, dw: dw_a};
            1:       o = '{lp: {3'b000, lp_b}, ld: ld_b, er: er_b,
                           pw: {1'b0, pw_b}, dw: {1'b0, dw_b}};
            default: o = '{lp: lp_c, ld: ld_c, er: er_c, pw: pw_c, dw: dw_c};
        endcase
        return o;
    endfunction

    task automatic step(input int sel, input string tag, input int n);
        obs_t o, e;
        for (int k = 0; k < n; k++) begin
            @(posedge slow_clock);
            #1;
            o = observe(sel);
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $error("FAIL %s scoreboard empty observed=%h", tag, o);
            end else begin
                e = sbq.pop_front();
                assert (o === e) else begin
                    errors++;
                    $error("FAIL %s cyc%0d observed=%h expected=%h", tag, k, o, e);
                end
            end
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_a = 1; rst_b = 1; rst_c = 1; adv_c = 0;
        ps_a = {4'd3, 4'd7}; pc3_a = 8'h05; ds_a = 4'd4;
        ps_b = 4'd6; pc3_b = 4'd0; ds_b = 4'd5;
        ps_c = {4'd6, 4'd7}; pc3_c = 8'h00; ds_c = 4'd6;

        // ---- configuration A: two players, auto advance ----
        push(0, 0, 0, 0, 0);
        step(0, "a_reset", 1);
        chk("a_reset_rc", rc_a, 0);
        chk("a_reset_tally", pt_a, 0);
        rst_a = 0;

        // player1 draws, dealer 4 with no player-0 draw takes third card
        push_base(2);
        push(6'd0, 3'b000, 0, 2'b00, 2'b00);
        push(6'b100000, 3'b000, 0, 2'b00, 2'b00);
        push(6'd0, 3'b100, 0, 2'b00, 2'b00);
        push(6'd0, 3'b000, 1, 2'b01, 2'b10);
        step(0, "a_round1", 10);
        chk("a_r1_rc", rc_a, 1);
        chk("a_r1_tally", pt_a, {8'd0, 8'd1});
        ds_a = 4'd9;

        // dealer natural ends the round right after DC2
        push(0, 0, 0, 0, 0);
        push_base(2);
        push(6'd0, 3'b000, 1, 2'b00, 2'b11);
        step(0, "a_round2", 8);
        chk("a_r2_rc", rc_a, 2);
        chk("a_r2_tally", pt_a, {8'd0, 8'd1});
        ps_a = {4'd7, 4'd2}; ds_a = 4'd3; pc3_a = 8'h08;

        // player0 draws an 8, dealer on 3 stands
        push(0, 0, 0, 0, 0);
        push_base(2);
        push(6'b000100, 3'b000, 0, 2'b00, 2'b00);
        push(6'd0, 3'b000, 0, 2'b00, 2'b00);
        push(6'd0, 3'b000, 1, 2'b10, 2'b01);
        step(0, "a_round3", 10);
        chk("a_r3_rc", rc_a, 3);
        chk("a_r3_tally", pt_a, {8'd1, 8'd1});
        ds_a = 4'd6; pc3_a = 8'h07;

        // player0 draws a 7, dealer on 6 draws
        push(0, 0, 0, 0, 0);
        push_base(2);
        push(6'b000100, 3'b000, 0, 2'b00, 2'b00);
        push(6'd0, 3'b000, 0, 2'b00, 2'b00);
        push(6'd0, 3'b100, 0, 2'b00, 2'b00);
        push(6'd0, 3'b000, 1, 2'b10, 2'b01);
        step(0, "a_round4", 11);
        chk("a_r4_rc", rc_a, 4);
        chk("a_r4_tally", pt_a, {8'd2, 8'd1});
        rst_a = 1;

        // ---- configuration B: single player ----
        rst_b = 0;
        push_base(1);
        push(6'd0, 3'b100, 0, 2'b00, 2'b00);
        push(6'd0, 3'b000, 1, 2'b01, 2'b00);
        step(1, "b_round1", 6);
        chk("b_r1_rc", rc_b, 1);
        chk("b_r1_tally", pt_b, 1);
        ds_b = 4'd6;

        push(0, 0, 0, 0, 0);
        push_base(1);
        push(6'd0, 3'b000, 1, 2'b01, 2'b01);
        step(1, "b_round2", 6);
        chk("b_r2_rc", rc_b, 2);
        chk("b_r2_tally", pt_b, 1);
        rst_b = 1;

        // ---- configuration C: held END, 2-bit saturating tallies ----
        rst_c = 0;
        push_base(2);
        for (int i = 0; i < 10; i++) push(6'd0, 3'b000, 1, 2'b11, 2'b10);
        step(2, "c_hold", 16);
        chk("c_hold_rc", rc_c, 1);
        chk("c_hold_tally", pt_c, 4'b0001);
        adv_c = 1;
        push(0, 0, 0, 0, 0);
        step(2, "c_advance", 1);
        for (int k = 2; k <= 5; k++) begin
            push_base(2);
            push(6'd0, 3'b000, 1, 2'b11, 2'b10);
            step(2, "c_round", 7);
            chk("c_sat_rc", rc_c, (k < 3) ? k : 3);
            chk("c_sat_tally", pt_c, (k < 3) ? k : 3);
            push(0, 0, 0, 0, 0);
            step(2, "c_rst", 1);
        end

        // async reset in the middle of P2
        push(6'b000001, 0, 0, 0, 0);
        push(6'b001000, 0, 0, 0, 0);
        push(6'd0, 3'b001, 0, 0, 0);
        push(6'b000010, 0, 0, 0, 0);
        step(2, "c_pre_reset", 4);
        #1;
        rst_c = 1;
        #1;
        chk("c_async_outputs", {lp_c, ld_c, er_c, pw_c, dw_c}, 0);
        chk("c_async_counters", {rc_c, pt_c}, 0);

        chk("sb_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/player_round_ctrl.md
PLAYER_ROUND_CTRL -- requirements
Module: player_round_ctrl

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2, number of player hands played against the dealer (legal 1..4).
REQ-002 SHALL have parameter TALLY_W, default 8, width of the round counter and the per-player win counters.
REQ-003 SHALL have parameter AUTO_ADVANCE, default 1; 1 = new round starts automatically after END, 0 = END holds until advance.
REQ-004 slow_clock  in  1  block clock; all state updates on its falling edge.
REQ-005 resetb  in  1  asynchronous, active-high reset; resetb=1 forces reset state immediately.
REQ-006 advance  in  1  step request; used only when AUTO_ADVANCE=0.
REQ-007 pscore  in  4*NUM_PLAYERS  current score of player i in bits [4i+3:4i], 0..9.
REQ-008 pcard3  in  4*NUM_PLAYERS  third-card value of player i in bits [4i+3:4i].
REQ-009 dscore  in  4  current dealer score, 0..9.
REQ-010 load_pcard  out  3*NUM_PLAYERS  bit 3i+k loads card k+1 of player i.
REQ-011 load_dcard  out  3  bit k loads dealer card k+1.
REQ-012 player_win_light, dealer_win_light  out  NUM_PLAYERS each  per-player result lights.
REQ-013 endround  out  1  high while in END.
REQ-014 round_count  out  TALLY_W  completed rounds, saturating.
REQ-015 player_tally  out  TALLY_W*NUM_PLAYERS  wins of player i in bits [TALLY_W*(i+1)-1:TALLY_W*i], saturating.

Function
REQ-016 FSM states SHALL be RST, P1, DC1, P2, DC2, P3, DC3, END, plus player index idx (0..NUM_PLAYERS-1).
REQ-017 Load outputs SHALL be Moore decodes of state: P1/P2/P3 assert only bit for player idx; DC1/DC2/DC3 assert load_dcard bit 0/1/2; one load bit at most per cycle.
REQ-018 Sequence SHALL be RST(1 cycle) -> P1 for idx=0..N-1 (one cycle each) -> DC1 -> P2 idx=0..N-1 -> DC2.
REQ-019 On the edge leaving DC2, draw_mask[i] SHALL latch 1 iff pscore[i]<=5, and nat0 SHALL latch 1 iff pscore[0]>=8.
REQ-020 Leaving DC2: dscore>=8 -> END; else any draw_mask bit set -> P3 with idx=0; else -> dealer decision (REQ-023).
REQ-021 P3 SHALL last exactly N cycles (idx 0..N-1); load_pcard bit 3idx+2 asserted only when draw_mask[idx]=1.
REQ-022 Dealer decision SHALL be evaluated on the edge leaving DC2 (no drawers) or leaving the last P3 cycle.
REQ-023 Dealer decision: if draw_mask[0]=1, go DC3 iff table on pcard3[0]: dscore 0-2 always; 3 unless pcard3=8; 4 if 2..7; 5 if 4..7; 6 if 6..7; 7 never; else END. If draw_mask[0]=0, go DC3 iff dscore<=5 and nat0=0; else END.
REQ-024 DC3 SHALL last one cycle then go to END.
REQ-025 In END per player i: pscore>dscore -> player light only; dscore>pscore -> dealer light only; equal -> both; endround=1; all loads 0.
REQ-026 On the edge entering END, round_count and player_tally[i] (for each i with pscore>dscore) SHALL increment by 1, saturating at all-ones; exactly once per round.
REQ-027 AUTO_ADVANCE=1: END SHALL last one cycle then RST. AUTO_ADVANCE=0: END SHALL hold until a falling edge samples advance=1, then RST; advance ignored elsewhere.
REQ-028 Outside END all win lights and endround SHALL be 0.
REQ-029 Illegal state/idx SHALL recover to RST on the next edge.

Reset
REQ-030 resetb=1 SHALL asynchronously set state RST, idx 0, draw_mask 0, nat0 0, round_count 0, all tallies 0, all outputs 0, including mid-round and in held END.
REQ-031 First transition after resetb falls SHALL be RST -> P1 idx 0.

Verification
REQ-032 N=2, pscore={7,3}, dscore=4, pcard3[0]=5 -> P1x2,DC1,P2x2,DC2,P3x2 (only player1 card3 loads), DC3, END; 11 cycles RST->END.
REQ-033 N=2, dscore=9 at DC2 -> END directly after DC2, no P3/DC3 loads; lights per REQ-025, round_count +1.
REQ-034 N=1, pscore=6, dscore=5 -> no P3, DC3 taken; pscore=6,dscore=6 -> END directly; equal scores -> both lights, tally unchanged.
REQ-035 AUTO_ADVANCE=0: END held 10 cycles with advance=0, counters increment once; advance=1 -> RST next edge.
REQ-036 TALLY_W=2: 5 player-0 wins -> player_tally[0]=3, round_count=3 (saturated); resetb=1 mid-P2 -> all outputs 0 immediately.
